// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte holding register.
// The serial input is synchronized, and a frame starts on a falling edge.
// Each bit is sampled at the middle of its bit time.
// Received bytes are offered to the CPU through a level irr/ack handshake.
// An overrun is flagged when a byte completes while the holding register is occupied.
// A framing error is flagged when the stop bit is sampled low.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       irr,
  input  logic       ack,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

  // Receive FSM encoding
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Holding FSM encoding
  localparam logic [1:0] H_EMPTY = 2'd0;
  localparam logic [1:0] H_FULL  = 2'd1;
  localparam logic [1:0] H_ACKED = 2'd2;

  logic             sync_meta_r;
  logic             rxd_s;
  logic             rxd_p;
  logic [1:0]       rx_state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_done_r;
  logic             stop_bad_r;
  logic [1:0]       hold_state_r;
  logic [1:0]       hold_next_s;
  logic             load_s;
  logic             drop_s;

  // Two-flop synchronizer on the pin plus a delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_r <= 1'b1;
      rxd_s       <= 1'b1;
      rxd_p       <= 1'b1;
    end else begin
      sync_meta_r <= rxd;
      rxd_s       <= sync_meta_r;
      rxd_p       <= rxd_s;
    end
  end

  // Receive FSM: start detection, mid-bit sampling and stop-bit check
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r  <= RX_IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'd0;
      byte_done_r <= 1'b0;
      stop_bad_r  <= 1'b0;
    end else begin
      byte_done_r <= 1'b0;
      stop_bad_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          cnt_r <= '0;
          if (!rxd_s && rxd_p) begin
            rx_state_r <= RX_START;
          end else begin
            rx_state_r <= RX_IDLE;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            // A high line at mid-start means the falling edge was only a glitch
            if (rxd_s) begin
              rx_state_r <= RX_IDLE;
            end else begin
              rx_state_r <= RX_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r            <= '0;
            shift_r[bit_idx_r] <= rxd_s;
            if (bit_idx_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r      <= '0;
            rx_state_r <= RX_IDLE;
            if (rxd_s) begin
              byte_done_r <= 1'b1;
            end else begin
              stop_bad_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          cnt_r      <= '0;
        end
      endcase
    end
  end

  // Holding FSM next state.
  // A completed byte is dropped whenever the CPU still owns the register or is still acknowledging.
  always_comb begin
    hold_next_s = hold_state_r;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    case (hold_state_r)
      H_EMPTY: begin
        // ack is ignored here so a stale acknowledge cannot retire an unseen byte
        if (byte_done_r) begin
          hold_next_s = H_FULL;
          load_s      = 1'b1;
        end else begin
          hold_next_s = H_EMPTY;
        end
      end
      H_FULL: begin
        drop_s = byte_done_r;
        if (ack) begin
          hold_next_s = H_ACKED;
        end else begin
          hold_next_s = H_FULL;
        end
      end
      H_ACKED: begin
        if (ack) begin
          hold_next_s = H_ACKED;
          drop_s      = byte_done_r;
        end else if (byte_done_r) begin
          hold_next_s = H_FULL;
          load_s      = 1'b1;
        end else begin
          hold_next_s = H_EMPTY;
        end
      end
      default: begin
        hold_next_s = H_EMPTY;
      end
    endcase
  end

  // Holding register, handshake state and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_state_r <= H_EMPTY;
      rx_data      <= 8'd0;
      irr          <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      hold_state_r <= hold_next_s;
      irr          <= (hold_next_s == H_FULL);
      frame_err    <= stop_bad_r;
      if (load_s) begin
        rx_data <= shift_r;
      end
      if (drop_s) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx with CLKS_PER_BIT=8.
// Frame timing is counted in clock edges from the start-bit falling edge.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic       ack;
  logic [7:0] rx_data;
  logic       irr;
  logic       overrun;
  logic       frame_err;

  int checks;
  int errors;
  int fe_count;
  int fe_base;

  uart_rx #(.CLKS_PER_BIT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .irr       (irr),
    .ack       (ack),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count frame_err cycles, sampled away from the active edge
  initial fe_count = 0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_count <= fe_count + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, 8 data bits LSB first, then the stop level held for stop_cycles edges.
  // With stop_cycles=7 the task returns just after the stop-bit sample edge (edge 79).
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int stop_cycles);
    rxd = 1'b0;
    step(8);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      step(8);
    end
    rxd = stop_bit;
    step(stop_cycles);
  endtask

  task automatic test_reset;
    reset = 1'b1; rxd = 1'b1; ack = 1'b0;
    step(3);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected %h", rx_data, 8'h00); end
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL reset_irr: got %b expected %b", irr, 1'b0); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected %b", overrun, 1'b0); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected %b", frame_err, 1'b0); end
    reset = 1'b0;
    step(4);
  endtask

  task automatic test_receive;
    drive_frame(8'hA5, 1'b1, 7);
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL rx_irr_early: got %b expected %b", irr, 1'b0); end
    step(1);
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL rx_irr_rise: got %b expected %b", irr, 1'b1); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL rx_data_a5: got %h expected %h", rx_data, 8'hA5); end
    ack = 1'b1;
    step(1);
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL rx_irr_fall: got %b expected %b", irr, 1'b0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL rx_data_hold: got %h expected %h", rx_data, 8'hA5); end
    ack = 1'b0;
    step(3);
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL rx_irr_after_ack: got %b expected %b", irr, 1'b0); end
  endtask

  task automatic test_glitch;
    fe_base = fe_count;
    rxd = 1'b0;
    step(2);
    rxd = 1'b1;
    step(20);
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL glitch_irr: got %b expected %b", irr, 1'b0); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL glitch_overrun: got %b expected %b", overrun, 1'b0); end
    checks++; if ((fe_count - fe_base) !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d pulses expected %0d", fe_count - fe_base, 0); end
  endtask

  task automatic test_frame_error;
    fe_base = fe_count;
    drive_frame(8'h3C, 1'b0, 7);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_early: got %b expected %b", frame_err, 1'b0); end
    step(1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_pulse: got %b expected %b", frame_err, 1'b1); end
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL fe_irr: got %b expected %b", irr, 1'b0); end
    step(1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_end: got %b expected %b", frame_err, 1'b0); end
    rxd = 1'b1;
    step(4);
    checks++; if ((fe_count - fe_base) !== 1) begin errors++; $display("FAIL fe_width: got %0d cycles expected %0d", fe_count - fe_base, 1); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL fe_rx_data: got %h expected %h", rx_data, 8'hA5); end
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL fe_irr_late: got %b expected %b", irr, 1'b0); end
  endtask

  task automatic test_back_to_back;
    drive_frame(8'h11, 1'b1, 8);
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL b2b_irr_first: got %b expected %b", irr, 1'b1); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_data_first: got %h expected %h", rx_data, 8'h11); end
    drive_frame(8'h22, 1'b1, 7);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_early: got %b expected %b", overrun, 1'b0); end
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL b2b_irr_mid: got %b expected %b", irr, 1'b1); end
    step(1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected %b", overrun, 1'b1); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_data_kept: got %h expected %h", rx_data, 8'h11); end
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL b2b_irr_kept: got %b expected %b", irr, 1'b1); end
    ack = 1'b1;
    step(2);
    ack = 1'b0;
    step(2);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky: got %b expected %b", overrun, 1'b1); end
  endtask

  task automatic test_ack_held;
    reset = 1'b1; step(2); reset = 1'b0; step(2);
    // ack left high after retiring 0x11: the next byte must be dropped
    drive_frame(8'h11, 1'b1, 8);
    ack = 1'b1;
    step(2);
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL ackh_retired: got %b expected %b", irr, 1'b0); end
    drive_frame(8'h22, 1'b1, 8);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ackh_overrun: got %b expected %b", overrun, 1'b1); end
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL ackh_irr: got %b expected %b", irr, 1'b0); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ackh_data: got %h expected %h", rx_data, 8'h11); end
    ack = 1'b0;
    step(2);
    // ack dropped before the stop-bit sample: byte accepted
    reset = 1'b1; step(2); reset = 1'b0; step(2);
    drive_frame(8'h11, 1'b1, 8);
    ack = 1'b1;
    step(2);
    drive_frame(8'h22, 1'b1, 6);
    ack = 1'b0;
    step(2);
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL ackl_irr: got %b expected %b", irr, 1'b1); end
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ackl_data: got %h expected %h", rx_data, 8'h22); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ackl_overrun: got %b expected %b", overrun, 1'b0); end
    // ack dropped right after the stop-bit sample: ACKED meets byte_done with ack low
    ack = 1'b1;
    step(2);
    drive_frame(8'h33, 1'b1, 7);
    ack = 1'b0;
    step(1);
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL acke_irr: got %b expected %b", irr, 1'b1); end
    checks++; if (rx_data !== 8'h33) begin errors++; $display("FAIL acke_data: got %h expected %h", rx_data, 8'h33); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL acke_overrun: got %b expected %b", overrun, 1'b0); end
    step(3);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'h5A;
    fe_base = fe_count;
    rxd = 1'b0;
    step(8);
    for (int i = 0; i < 3; i++) begin
      rxd = d[i];
      step(8);
    end
    rxd = d[3];
    step(4);
    reset = 1'b1;
    step(1);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_rx_data: got %h expected %h", rx_data, 8'h00); end
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL mid_irr: got %b expected %b", irr, 1'b0); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b expected %b", overrun, 1'b0); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_frame_err: got %b expected %b", frame_err, 1'b0); end
    reset = 1'b0;
    rxd = 1'b1;
    step(20);
    drive_frame(8'h5A, 1'b1, 8);
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL mid_next_irr: got %b expected %b", irr, 1'b1); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL mid_next_data: got %h expected %h", rx_data, 8'h5A); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_next_overrun: got %b expected %b", overrun, 1'b0); end
    checks++; if ((fe_count - fe_base) !== 0) begin errors++; $display("FAIL mid_no_fe: got %0d pulses expected %0d", fe_count - fe_base, 0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    rxd    = 1'b1;
    ack    = 1'b0;
    test_reset;
    test_receive;
    test_glitch;
    test_frame_error;
    test_back_to_back;
    test_ack_held;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver feeding the CPU's receive path: it deserializes 8N1 frames from the serial input pin and presents each byte on `rx_data`. Reception is signalled with a level interrupt request `irr`, which the CPU retires through a four-phase `irr`/`ack` handshake. The block sits between the board RX pin and the CPU's `irr`/`ack`/`rx_data` ports. It holds one received byte and reports overrun and framing errors.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200 baud); must be ≥ 4.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  8  last accepted byte; stable while `irr`=1.
- `irr`  out  1  byte available; level signal.
- `ack`  in  1  CPU acknowledge; level signal; may stay high for many cycles.
- `overrun`  out  1  sticky flag: a completed byte was dropped because the holding register was occupied.
- `frame_err`  out  1  one-cycle pulse: a stop bit was sampled low.

## Operation
- **Synchronizer.** `rxd` passes through a 2-flop synchronizer (both flops reset to 1) to give `rxd_s`. A further register `rxd_p` holds the previous `rxd_s`.
- **Bit counter.** Width is $clog2(CLKS_PER_BIT). Bit index is 3 bits. Shift register is 8 bits, filled LSB first.
- **Receive FSM.**
  - IDLE: moves to START when `rxd_s`=0 and `rxd_p`=1 (falling edge only; a held-low line does not retrigger). Bit counter is cleared on entry.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample `rxd_s`. If 0, go to DATA with counter cleared and bit index 0. If 1, the start was a glitch; return to IDLE with no flags.
  - DATA: every CLKS_PER_BIT cycles, sample `rxd_s` into shift[index]. After index 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxd_s`. If 1, raise internal `byte_done` for 1 cycle. If 0, pulse `frame_err` for 1 cycle and discard the byte. Both cases return to IDLE.
- **Holding FSM.**
  - EMPTY: on `byte_done`, load `rx_data` from the shift register and go to FULL.
  - FULL: `irr`=1. When `ack`=1, go to ACKED.
  - ACKED: `irr`=0. When `ack`=0, go to EMPTY.
- **Simultaneous events.**
  - `byte_done` while FULL, or while ACKED with `ack`=1: byte dropped, `overrun` set to 1, `rx_data` unchanged.
  - `byte_done` while ACKED with `ack`=0: byte accepted, go directly to FULL.
- `overrun` clears only on reset.
- `ack` is ignored in EMPTY, so a stale `ack`=1 can never retire a byte that has not yet been presented.

## Timing
- **Reset values.** `rx_data`=0, `irr`=0, `overrun`=0, `frame_err`=0. Receive FSM in IDLE, holding FSM in EMPTY, synchronizer flops = 1.
- **Reset mid-frame.** Aborts the frame with no flags. Reception restarts at the next falling edge after reset deasserts.
- **Start-detect latency.** 3 cycles from the `rxd` edge: 2 synchronizer cycles plus 1 edge-detect cycle.
- **Sample points.** Data bit k is sampled at (3 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT) cycles after the start edge; the stop bit is sampled one CLKS_PER_BIT later.
- **`irr` assertion.** `irr` and the new `rx_data` appear 1 cycle after the stop-bit sample.
- **`irr` deassertion.** `irr` drops 1 cycle after `ack` is first seen high in FULL.
- **`frame_err`.** Asserted the cycle after the stop-bit sample, for exactly 1 cycle.
- **`overrun`.** Rises the cycle after the dropping `byte_done`.
- **Back-to-back frames.** Supported: IDLE accepts a start edge in the cycle after STOP.

## Test plan
All scenarios use CLKS_PER_BIT=8.
1. Send 0xA5 with stop=1, `ack`=0:
   - `irr` rises 3+4+72+1=80 cycles after the start edge, with `rx_data`=0xA5.
   - Raise `ack`: `irr` falls the next cycle.
   - Drop `ack`: holding FSM returns to EMPTY.
2. Drive `rxd` low for 2 cycles, then high:
   - Receive FSM returns to IDLE after the half-bit check.
   - `irr`, `frame_err` and `overrun` all stay 0.
3. Send 0x3C with stop bit = 0:
   - `frame_err` is high for exactly 1 cycle.
   - `irr` stays 0 and `rx_data` is unchanged.
4. Send 0x11 then 0x22 back-to-back, `ack` held 0:
   - `rx_data`=0x11 and `irr`=1 throughout.
   - `overrun`=1 after the second stop-bit sample.
5. Send 0x11 and retire it while leaving `ack`=1, then send 0x22:
   - 0x22 is dropped and `overrun`=1.
   - Repeat with `ack` lowered before the stop-bit sample: 0x22 is accepted and `overrun` stays 0.
6. Assert reset during data bit 3 of a frame:
   - All outputs are 0 the next cycle.
   - A following 0x5A frame is received correctly with `overrun`=0.
